// File: rtl/mem_access_unit.sv
// Data-memory load/store unit: turns decoded memory controls into a req/ack bus
// transaction, aligns/extends load data and holds the core stalled while busy.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        memtoreg,
  input  logic        mem_signed,
  input  logic [1:0]  mem_length,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] wb_data,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_error
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          req_q, we_q, mis_q, berr_q, sgn_q;
  logic [1:0]    off_q, len_q;
  logic [31:0]   addr_q, wdata_q, load_q;
  logic [3:0]    be_q;

  logic        access_s, misalign_s, start_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s, shifted_s, load_ext_s;
  logic [15:0] half_s;

  assign access_s   = memread | memwrite;
  assign misalign_s = (mem_length == 2'b11) ||
                      ((mem_length == 2'b01) && alu_result[0]) ||
                      ((mem_length == 2'b10) && (alu_result[1:0] != 2'b00));
  assign start_s    = (state_q == IDLE) && access_s && !misalign_s;

  // Lane enables and store-data replication for the incoming instruction.
  always_comb begin
    be_s    = 4'b0000;
    wdata_s = 32'd0;
    case (mem_length)
      2'b00: begin
        be_s    = 4'b0001 << alu_result[1:0];
        wdata_s = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_s    = alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_s = {2{store_data[15:0]}};
      end
      2'b10: begin
        be_s    = 4'b1111;
        wdata_s = store_data;
      end
      default: begin
        be_s    = 4'b0000;
        wdata_s = 32'd0;
      end
    endcase
  end

  // Load lane extraction uses the offset/size captured at request time.
  assign shifted_s = mem_rdata >> {off_q, 3'b000};
  assign half_s    = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    load_ext_s = mem_rdata;
    case (len_q)
      2'b00:   load_ext_s = {{24{sgn_q & shifted_s[7]}}, shifted_s[7:0]};
      2'b01:   load_ext_s = {{16{sgn_q & half_s[15]}}, half_s};
      default: load_ext_s = mem_rdata;
    endcase
  end

  // Transaction FSM; a late ack in the timeout cycle still completes normally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
      sgn_q   <= 1'b0;
      off_q   <= 2'b00;
      len_q   <= 2'b00;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      load_q  <= 32'd0;
      be_q    <= 4'b0000;
    end else begin
      mis_q  <= 1'b0;
      berr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_s) begin
            state_q <= ACCESS;
            req_q   <= 1'b1;
            we_q    <= memwrite;
            be_q    <= be_s;
            wdata_q <= wdata_s;
            addr_q  <= {alu_result[31:2], 2'b00};
            off_q   <= alu_result[1:0];
            len_q   <= mem_length;
            sgn_q   <= mem_signed;
            cnt_q   <= '0;
          end else if (access_s) begin
            mis_q <= 1'b1;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            load_q  <= load_ext_s;
            req_q   <= 1'b0;
            state_q <= DONE;
          end else if (cnt_q == CNT_MAX) begin
            load_q  <= 32'd0;
            berr_q  <= 1'b1;
            req_q   <= 1'b0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_be     = be_q;
  assign mem_wdata  = wdata_q;
  assign misaligned = mis_q;
  assign bus_error  = berr_q;
  assign stall      = start_s || (state_q == ACCESS);
  assign wb_data    = memtoreg ? load_q : alu_result;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, reset cases
// and randomized transactions against an arithmetic reference model.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        memread, memwrite, memtoreg, mem_signed;
  logic [1:0]  mem_length;
  logic [31:0] alu_result, store_data;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, wb_data;
  logic [3:0]  mem_be;
  logic        stall, misaligned, bus_error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rd, wr, mtr, sgn;
    logic [1:0]  len;
    logic [31:0] addr, sdata;
    int          ack_delay;
    logic [31:0] rdata;
    logic [31:0] exp_wb;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_mis, exp_berr;
  } vec_t;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .memread(memread), .memwrite(memwrite),
    .memtoreg(memtoreg), .mem_signed(mem_signed), .mem_length(mem_length),
    .alu_result(alu_result), .store_data(store_data), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_data(wb_data), .stall(stall),
    .misaligned(misaligned), .bus_error(bus_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: sizes in bytes, shifts and masks.
  function automatic logic model_mis(input logic [1:0] len, input logic [31:0] addr);
    int unsigned nb;
    nb = 1 << len;
    return (len == 2'd3) || ((addr % nb) != 0);
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] len, input logic [31:0] addr);
    int unsigned nb;
    nb = 1 << len;
    return 4'(((1 << nb) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] len, input logic [31:0] sd);
    if (len == 2'd0) return (sd & 32'hFF) * 32'h0101_0101;
    if (len == 2'd1) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] len, input logic [31:0] addr,
                                             input logic sgn, input logic [31:0] rd);
    logic [31:0] mask, lane, top;
    int unsigned nb;
    if (len == 2'd2) return rd;
    nb   = 1 << len;
    mask = (32'd1 << (8 * nb)) - 32'd1;
    top  = 32'd1 << (8 * nb - 1);
    lane = (rd >> (8 * (addr % 4))) & mask;
    if (sgn && ((lane & top) != 32'd0)) lane = lane | ~mask;
    return lane;
  endfunction

  task automatic idle_inputs();
    memread = 1'b0; memwrite = 1'b0; mem_ack = 1'b0;
  endtask

  // Called just after a rising edge with the DUT idle.
  task automatic run_vec(input vec_t v);
    int ncyc, exp_cyc;
    bit fin;
    memread = v.rd; memwrite = v.wr; memtoreg = v.mtr; mem_signed = v.sgn;
    mem_length = v.len; alu_result = v.addr; store_data = v.sdata; mem_ack = 1'b0;
    @(negedge clock);
    if (v.exp_mis) begin
      chk("mis_stall", 32'(stall), 32'd0);
      chk("mis_req", 32'(mem_req), 32'd0);
      @(posedge clock); #1; idle_inputs();
      @(negedge clock);
      chk("mis_pulse", 32'(misaligned), 32'd1);
      chk("mis_req_after", 32'(mem_req), 32'd0);
      @(posedge clock); #1;
      @(negedge clock);
      chk("mis_clear", 32'(misaligned), 32'd0);
    end else begin
      chk("start_stall", 32'(stall), 32'd1);
      chk("start_req", 32'(mem_req), 32'd0);
      exp_cyc = (v.ack_delay < TO) ? v.ack_delay + 1 : TO;
      ncyc = 0; fin = 0;
      while (!fin) begin
        @(posedge clock); #1;
        mem_ack   = (ncyc == v.ack_delay);
        mem_rdata = mem_ack ? v.rdata : $urandom;
        @(negedge clock);
        chk("acc_req", 32'(mem_req), 32'd1);
        chk("acc_stall", 32'(stall), 32'd1);
        chk("acc_we", 32'(mem_we), 32'(v.wr));
        chk("acc_addr", mem_addr, v.addr & 32'hFFFF_FFFC);
        chk("acc_be", 32'(mem_be), 32'(v.exp_be));
        chk("acc_wdata", mem_wdata, v.exp_wdata);
        ncyc++;
        if (mem_ack || ncyc >= TO) fin = 1;
      end
      chk("acc_cycles", 32'(ncyc), 32'(exp_cyc));
      @(posedge clock); #1; mem_ack = 1'b0;
      @(negedge clock);
      chk("done_req", 32'(mem_req), 32'd0);
      chk("done_stall", 32'(stall), 32'd0);
      chk("done_berr", 32'(bus_error), 32'(v.exp_berr));
      chk("done_wb", wb_data, v.exp_wb);
      @(posedge clock); #1; idle_inputs();
      @(negedge clock);
      chk("idle_berr", 32'(bus_error), 32'd0);
      chk("idle_req", 32'(mem_req), 32'd0);
    end
    @(posedge clock); #1;
  endtask

  vec_t tbl[9];
  vec_t rv;

  initial begin
    //            rd    wr    mtr   sgn   len    addr          sdata         dly  rdata          exp_wb        be       wdata         mis   berr
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 32'h0000_1003, 32'h0,        0,  32'h80FF_0000, 32'hFFFF_FF80, 4'b1000, 32'h0,        1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0000_1003, 32'h0,        0,  32'h80FF_0000, 32'h0000_0080, 4'b1000, 32'h0,        1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 32'h0000_2002, 32'h1234_ABCD, 3, 32'h0,        32'h0000_2002, 4'b1100, 32'hABCD_ABCD, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 32'h0000_3001, 32'h0,        0,  32'h0,        32'h0,        4'b0000, 32'h0,        1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 32'h0000_3000, 32'h0,        0,  32'h0,        32'h0,        4'b0000, 32'h0,        1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 32'h0000_4000, 32'h0,        99, 32'h0,        32'h0,        4'b1111, 32'h0,        1'b0, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 32'h0000_4000, 32'h0,        3,  32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111, 32'h0,        1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 32'h0000_5002, 32'h0,        1,  32'h8001_1234, 32'hFFFF_8001, 4'b1100, 32'h0,        1'b0, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_6001, 32'h0000_00A5, 0, 32'h0,        32'h0000_6001, 4'b0010, 32'hA5A5_A5A5, 1'b0, 1'b0};

    reset = 1'b0; idle_inputs(); memtoreg = 1'b1; mem_signed = 1'b0;
    mem_length = 2'b00; alu_result = 32'h0; store_data = 32'h0; mem_rdata = 32'h0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_mis", 32'(misaligned), 32'd0);
    chk("rst_berr", 32'(bus_error), 32'd0);
    chk("rst_wb", wb_data, 32'd0);
    @(posedge clock); #1; reset = 1'b1;

    // Pass-through with zero latency.
    @(posedge clock); #1;
    memtoreg = 1'b0; alu_result = 32'hDEAD_BEEF;
    #1;
    chk("pass_wb", wb_data, 32'hDEAD_BEEF);
    chk("pass_stall", 32'(stall), 32'd0);
    @(posedge clock); #1;

    for (int i = 0; i < 9; i++) run_vec(tbl[i]);

    // Reset asserted mid-ACCESS drops the request before the next edge.
    memread = 1'b1; memwrite = 1'b0; memtoreg = 1'b1; mem_length = 2'b10;
    alu_result = 32'h0000_7000; mem_ack = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    chk("mid_req_before", 32'(mem_req), 32'd1);
    #1; reset = 1'b0; #1;
    chk("mid_req_after", 32'(mem_req), 32'd0);
    idle_inputs(); #1;
    chk("mid_stall", 32'(stall), 32'd0);
    chk("mid_wb", wb_data, 32'd0);
    @(posedge clock); #1; reset = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 60; i++) begin
      rv.len   = 2'($urandom_range(0, 3));
      rv.addr  = $urandom;
      rv.sdata = $urandom;
      rv.rdata = $urandom;
      rv.sgn   = 1'($urandom);
      case ($urandom_range(0, 5))
        0:       begin rv.rd = 1'b0; rv.wr = 1'b0; end
        1, 2:    begin rv.rd = 1'b0; rv.wr = 1'b1; end
        3:       begin rv.rd = 1'b1; rv.wr = 1'b1; end
        default: begin rv.rd = 1'b1; rv.wr = 1'b0; end
      endcase
      if (!model_mis(rv.len, rv.addr) && ($urandom_range(0, 1) == 0))
        rv.addr = rv.addr & ~((32'd1 << rv.len) - 32'd1);
      rv.mtr       = rv.rd & ~rv.wr;
      rv.ack_delay = $urandom_range(0, TO);
      if (rv.ack_delay == TO) rv.ack_delay = 99;
      rv.exp_mis   = model_mis(rv.len, rv.addr);
      rv.exp_berr  = (rv.ack_delay >= TO);
      rv.exp_be    = model_be(rv.len, rv.addr);
      rv.exp_wdata = model_wdata(rv.len, rv.sdata);
      if (!rv.mtr)          rv.exp_wb = rv.addr;
      else if (rv.exp_berr) rv.exp_wb = 32'd0;
      else                  rv.exp_wb = model_load(rv.len, rv.addr, rv.sgn, rv.rdata);
      if (!rv.rd && !rv.wr) begin
        memread = 1'b0; memwrite = 1'b0; memtoreg = 1'b0; alu_result = rv.addr;
        #1;
        chk("rnd_pass_wb", wb_data, rv.addr);
        chk("rnd_pass_stall", 32'(stall), 32'd0);
        @(posedge clock); #1;
        chk("rnd_pass_req", 32'(mem_req), 32'd0);
      end else begin
        run_vec(rv);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
